// File: rtl/sram_port_arbiter.sv
// Shares one single-port 64-bit SRAM between instruction fetch (I) and the memory stage (D).
// Grants are combinational each cycle; read data returns next cycle and is held per port until taken.
module sram_port_arbiter #(
   parameter int RR_MODE      = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [63:0] i_addr,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [63:0] i_rdata,
   input  logic        i_rready,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [7:0]  d_wstrb,
   input  logic [63:0] d_addr,
   input  logic [63:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [63:0] d_rdata,
   input  logic        d_rready,
   output logic        sram_en,
   output logic [7:0]  sram_wen,
   output logic [63:0] sram_addr,
   output logic [63:0] sram_wdata,
   input  logic [63:0] sram_rdata
);
   localparam int            CW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      SLOT_EMPTY = 2'd0,
      SLOT_PEND  = 2'd1,
      SLOT_HELD  = 2'd2
   } slot_t;

   slot_t         r_i_slot;
   slot_t         r_d_slot;
   slot_t         w_i_slot_nxt;
   slot_t         w_d_slot_nxt;
   logic [63:0]   r_i_hold;
   logic [63:0]   r_d_hold;
   logic          r_rr_d_next;
   logic [CW-1:0] r_starve;
   logic          w_i_elig;
   logic          w_d_elig;
   logic          w_contend;
   logic          w_d_rd_gnt;

   // A slot re-enters PEND straight from PEND when its result is taken and a new read wins the same cycle.
   function automatic slot_t f_slot_nxt(input slot_t cur, input logic rready, input logic rd_gnt);
      slot_t nxt;
      nxt = cur;
      case (cur)
         SLOT_EMPTY: nxt = rd_gnt ? SLOT_PEND : SLOT_EMPTY;
         SLOT_PEND:  nxt = !rready ? SLOT_HELD : (rd_gnt ? SLOT_PEND : SLOT_EMPTY);
         SLOT_HELD:  nxt = rready ? SLOT_EMPTY : SLOT_HELD;
         default:    nxt = SLOT_EMPTY;
      endcase
      return nxt;
   endfunction

   assign w_i_elig  = i_req & ((r_i_slot == SLOT_EMPTY) | ((r_i_slot == SLOT_PEND) & i_rready));
   assign w_d_elig  = d_req & ((r_d_slot == SLOT_EMPTY) | ((r_d_slot == SLOT_PEND) & d_rready));
   assign w_contend = w_i_elig & w_d_elig;

   always_comb begin
      i_gnt = 1'b0;
      d_gnt = 1'b0;
      if (!reset) begin
         if (w_contend) begin
            if (RR_MODE != 0) begin
               i_gnt = ~r_rr_d_next;
               d_gnt = r_rr_d_next;
            end else if (r_starve == STARVE_MAX) begin
               i_gnt = 1'b1;
            end else begin
               d_gnt = 1'b1;
            end
         end else begin
            i_gnt = w_i_elig;
            d_gnt = w_d_elig;
         end
      end
   end

   assign w_d_rd_gnt = d_gnt & ~d_we;
   assign sram_en    = i_gnt | d_gnt;
   assign sram_addr  = d_gnt ? d_addr : i_addr;
   assign sram_wen   = (d_gnt & d_we) ? d_wstrb : 8'h00;
   assign sram_wdata = d_wdata;

   always_comb begin
      w_i_slot_nxt = f_slot_nxt(r_i_slot, i_rready, i_gnt);
      w_d_slot_nxt = f_slot_nxt(r_d_slot, d_rready, w_d_rd_gnt);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_i_slot    <= SLOT_EMPTY;
         r_d_slot    <= SLOT_EMPTY;
         r_rr_d_next <= 1'b0;
         r_starve    <= '0;
      end else begin
         r_i_slot <= w_i_slot_nxt;
         r_d_slot <= w_d_slot_nxt;
         if (w_contend) begin
            r_rr_d_next <= i_gnt;
         end
         if (!i_req || i_gnt) begin
            r_starve <= '0;
         end else if (d_gnt && w_i_elig && (r_starve != STARVE_MAX)) begin
            r_starve <= r_starve + CW'(1);
         end
      end
   end

   // The SRAM output only lives one cycle, so an unconsumed result is parked here.
   always_ff @(posedge clk) begin
      if ((r_i_slot == SLOT_PEND) && !i_rready) begin
         r_i_hold <= sram_rdata;
      end
      if ((r_d_slot == SLOT_PEND) && !d_rready) begin
         r_d_hold <= sram_rdata;
      end
   end

   assign i_rvalid = ~reset & (r_i_slot != SLOT_EMPTY);
   assign d_rvalid = ~reset & (r_d_slot != SLOT_EMPTY);
   assign i_rdata  = (r_i_slot == SLOT_HELD) ? r_i_hold : sram_rdata;
   assign d_rdata  = (r_d_slot == SLOT_HELD) ? r_d_hold : sram_rdata;

endmodule
